// File: rtl/game_pkg.sv
// Shared stage encoding, default game constants and small helpers used by
// the stage controller and its per-fighter health blocks.
package game_pkg;

    typedef enum logic [1:0] {
        START  = 2'd0,
        BATTLE = 2'd1,
        WIN    = 2'd2,
        LOSE   = 2'd3
    } stage_t;

    localparam int HEALTH_MAX_DEF    = 5;
    localparam int IFRAMES_DEF       = 32;
    localparam int RESULT_FRAMES_DEF = 180;
    localparam int HEALTH_W          = 3;

    // Bits needed to hold a down-counter that starts at max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // One-hot flag vector {start, battle, win, lose} for a stage.
    function automatic logic [3:0] stage_flags(input stage_t s);
        logic [3:0] f;
        f = 4'b0000;
        case (s)
            START:   f = 4'b1000;
            BATTLE:  f = 4'b0100;
            WIN:     f = 4'b0010;
            LOSE:    f = 4'b0001;
            default: f = 4'b1000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fighter_health.sv
// Health and hit-immunity tracking for one fighter, with the thermometer
// mask that drives that fighter's on-screen health bar.
module fighter_health
    import game_pkg::*;
#(
    parameter int HEALTH_MAX = HEALTH_MAX_DEF,
    parameter int IFRAMES    = IFRAMES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  active,
    input  logic                  hit,
    input  logic                  frame_tick,
    output logic [HEALTH_W-1:0]   health,
    output logic [HEALTH_MAX-1:0] seg
);

    localparam int IMM_W = cnt_width(IFRAMES);

    logic [IMM_W-1:0] immunity;
    logic             hit_ok;

    // A hit only counts during battle, outside the immunity window, and
    // while there is still health left to take away.
    assign hit_ok = active && hit && (immunity == '0) && (health != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health   <= HEALTH_W'(HEALTH_MAX);
            immunity <= '0;
        end else if (load) begin
            health   <= HEALTH_W'(HEALTH_MAX);
            immunity <= '0;
        end else if (hit_ok) begin
            health   <= health - HEALTH_W'(1);
            immunity <= IMM_W'(IFRAMES);
        end else if (frame_tick && (immunity != '0)) begin
            immunity <= immunity - IMM_W'(1);
        end
    end

    always_comb begin
        seg = '0;
        if (active) begin
            for (int i = 0; i < HEALTH_MAX; i++) begin
                seg[i] = (int'(health) > i);
            end
        end
    end

endmodule

// File: rtl/game_stage_controller.sv
// Top-level game flow: START -> BATTLE -> WIN/LOSE -> START, with frame
// timing derived from VGA vsync and two fighter health trackers.
module game_stage_controller
    import game_pkg::*;
#(
    parameter int HEALTH_MAX    = HEALTH_MAX_DEF,
    parameter int IFRAMES       = IFRAMES_DEF,
    parameter int RESULT_FRAMES = RESULT_FRAMES_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic                  start_key,
    input  logic                  player_hit,
    input  logic                  npc_hit,
    output logic                  start_l,
    output logic                  battle_l,
    output logic                  win_l,
    output logic                  lose_l,
    output logic [HEALTH_MAX-1:0] player_health_seg,
    output logic [HEALTH_MAX-1:0] npc_health_seg,
    output logic [HEALTH_W-1:0]   player_health,
    output logic [HEALTH_W-1:0]   npc_health,
    output logic                  game_active
);

    localparam int RES_W = cnt_width(RESULT_FRAMES);

    logic             fc_s1, fc_s2, fc_s3;
    logic             frame_tick;
    logic             key_q, key_d;
    logic             start_edge;
    stage_t           state;
    logic [RES_W-1:0] result_cnt;
    logic             in_battle;
    logic             battle_load;

    // vsync is asynchronous to Clk: two flops to synchronize, a third to
    // remember the previous level for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_s1 <= 1'b0;
            fc_s2 <= 1'b0;
            fc_s3 <= 1'b0;
            key_q <= 1'b0;
            key_d <= 1'b0;
        end else begin
            fc_s1 <= frame_clk;
            fc_s2 <= fc_s1;
            fc_s3 <= fc_s2;
            key_q <= start_key;
            key_d <= key_q;
        end
    end

    assign frame_tick  = fc_s2 & ~fc_s3;
    assign start_edge  = key_q & ~key_d;
    assign in_battle   = (state == BATTLE);
    assign battle_load = (state == START) && start_edge;

    // Flags are updated together with the state so they change on the
    // same edge as the stage itself.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state                                 <= START;
            {start_l, battle_l, win_l, lose_l}    <= stage_flags(START);
            game_active                           <= 1'b0;
            result_cnt                            <= '0;
        end else begin
            case (state)
                START: begin
                    if (start_edge) begin
                        state                              <= BATTLE;
                        {start_l, battle_l, win_l, lose_l} <= stage_flags(BATTLE);
                        game_active                        <= 1'b1;
                    end
                end
                BATTLE: begin
                    if (player_health == '0) begin
                        state                              <= LOSE;
                        {start_l, battle_l, win_l, lose_l} <= stage_flags(LOSE);
                        game_active                        <= 1'b0;
                        result_cnt                         <= RES_W'(RESULT_FRAMES);
                    end else if (npc_health == '0) begin
                        state                              <= WIN;
                        {start_l, battle_l, win_l, lose_l} <= stage_flags(WIN);
                        game_active                        <= 1'b0;
                        result_cnt                         <= RES_W'(RESULT_FRAMES);
                    end
                end
                WIN, LOSE: begin
                    if (start_edge || (result_cnt == '0)) begin
                        state                              <= START;
                        {start_l, battle_l, win_l, lose_l} <= stage_flags(START);
                        game_active                        <= 1'b0;
                    end else if (frame_tick) begin
                        result_cnt <= result_cnt - RES_W'(1);
                    end
                end
                default: begin
                    state                              <= START;
                    {start_l, battle_l, win_l, lose_l} <= stage_flags(START);
                    game_active                        <= 1'b0;
                end
            endcase
        end
    end

    fighter_health #(
        .HEALTH_MAX (HEALTH_MAX),
        .IFRAMES    (IFRAMES)
    ) u_player (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (battle_load),
        .active     (in_battle),
        .hit        (player_hit),
        .frame_tick (frame_tick),
        .health     (player_health),
        .seg        (player_health_seg)
    );

    fighter_health #(
        .HEALTH_MAX (HEALTH_MAX),
        .IFRAMES    (IFRAMES)
    ) u_npc (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .load       (battle_load),
        .active     (in_battle),
        .hit        (npc_hit),
        .frame_tick (frame_tick),
        .health     (npc_health),
        .seg        (npc_health_seg)
    );

endmodule

// File: tb/tb_game_stage_controller.sv
// Directed bench for the stage controller: start, immunity windows, win hold,
// simultaneous knockout, early exit from LOSE and mid-battle reset.
module tb_game_stage_controller;

    logic       Clk;
    logic       Reset_n;
    logic       frame_clk;
    logic       start_key;
    logic       player_hit;
    logic       npc_hit;
    logic       start_l, battle_l, win_l, lose_l;
    logic [4:0] player_health_seg, npc_health_seg;
    logic [2:0] player_health, npc_health;
    logic       game_active;

    int checks;
    int errors;

    game_stage_controller dut (
        .Clk               (Clk),
        .Reset_n           (Reset_n),
        .frame_clk         (frame_clk),
        .start_key         (start_key),
        .player_hit        (player_hit),
        .npc_hit           (npc_hit),
        .start_l           (start_l),
        .battle_l          (battle_l),
        .win_l             (win_l),
        .lose_l            (lose_l),
        .player_health_seg (player_health_seg),
        .npc_health_seg    (npc_health_seg),
        .player_health     (player_health),
        .npc_health        (npc_health),
        .game_active       (game_active)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            repeat (3) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (3) @(negedge Clk);
        end
    endtask

    task automatic press_start();
        start_key = 1'b1;
        @(negedge Clk);
        start_key = 1'b0;
    endtask

    task automatic hit(input logic p, input logic n);
        player_hit = p;
        npc_hit    = n;
        @(negedge Clk);
        player_hit = 1'b0;
        npc_hit    = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        Reset_n    = 1'b0;
        frame_clk  = 1'b0;
        start_key  = 1'b0;
        player_hit = 1'b0;
        npc_hit    = 1'b0;
        repeat (2) @(negedge Clk);

        check("rst_start_l", start_l, 1);
        check("rst_flags", {battle_l, win_l, lose_l}, 0);
        check("rst_health", {player_health, npc_health}, {3'd5, 3'd5});
        check("rst_masks", {player_health_seg, npc_health_seg}, 0);
        check("rst_active", game_active, 0);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Start: battle flag two clocks after the key edge
        press_start();
        check("start_not_yet", battle_l, 0);
        @(negedge Clk);
        check("start_battle", battle_l, 1);
        check("start_start_l", start_l, 0);
        check("start_active", game_active, 1);
        check("start_masks", {player_health_seg, npc_health_seg}, 10'b11111_11111);
        check("start_health", {player_health, npc_health}, {3'd5, 3'd5});

        // Immunity window
        hit(1'b0, 1'b1);
        check("hit1", npc_health, 4);
        frames(10);
        hit(1'b0, 1'b1);
        check("hit_f10_ignored", npc_health, 4);
        frames(21);
        hit(1'b0, 1'b1);
        check("hit_f31_ignored", npc_health, 4);
        frames(1);
        hit(1'b0, 1'b1);
        check("hit_f32_lands", npc_health, 3);
        check("seg_3", npc_health_seg, 5'b00111);
        frames(32);
        hit(1'b0, 1'b1);
        check("seg_2", npc_health_seg, 5'b00011);
        frames(32);
        hit(1'b0, 1'b1);
        check("npc_1", npc_health, 1);
        frames(32);
        hit(1'b0, 1'b1);
        check("npc_0", npc_health, 0);
        check("npc_seg_0", npc_health_seg, 0);
        check("still_battle", battle_l, 1);
        @(negedge Clk);
        check("win_l", win_l, 1);
        check("win_battle_off", {battle_l, game_active}, 0);
        check("win_player_full", player_health, 5);

        // Hits outside battle are ignored; WIN holds for RESULT_FRAMES
        hit(1'b1, 1'b0);
        check("win_hit_ignored", player_health, 5);
        check("win_masks", {player_health_seg, npc_health_seg}, 0);
        frames(179);
        check("win_hold_179", win_l, 1);
        frames(1);
        check("win_to_start", start_l, 1);
        check("win_to_start_w", win_l, 0);
        check("start_retain", npc_health, 0);

        // Simultaneous knockout -> LOSE
        press_start();
        @(negedge Clk);
        check("b2_battle", battle_l, 1);
        check("b2_reload", {player_health, npc_health}, {3'd5, 3'd5});
        for (int i = 0; i < 4; i++) begin
            hit(1'b1, 1'b1);
            frames(32);
        end
        check("both_1", {player_health, npc_health}, {3'd1, 3'd1});
        hit(1'b1, 1'b1);
        @(negedge Clk);
        check("tie_lose", lose_l, 1);
        check("tie_not_win", win_l, 0);
        check("tie_counts", {player_health, npc_health}, 0);

        // Early exit from LOSE
        frames(20);
        check("lose_f20", lose_l, 1);
        press_start();
        check("lose_exit_pending", lose_l, 1);
        @(negedge Clk);
        check("lose_exit_start", start_l, 1);
        check("lose_exit_l", lose_l, 0);
        repeat (5) @(negedge Clk);
        check("no_auto_battle", battle_l, 0);

        // Asynchronous reset mid-battle
        press_start();
        @(negedge Clk);
        check("b3_battle", battle_l, 1);
        for (int i = 0; i < 3; i++) begin
            hit(1'b0, 1'b1);
            frames(32);
        end
        check("b3_npc_2", npc_health, 2);
        #2 Reset_n = 1'b0;
        #1;
        check("async_start_l", start_l, 1);
        check("async_battle_l", battle_l, 0);
        check("async_npc", npc_health, 5);
        check("async_mask_active", {npc_health_seg, game_active}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        press_start();
        @(negedge Clk);
        check("b4_battle", battle_l, 1);
        check("b4_npc", npc_health, 5);
        check("b4_seg", npc_health_seg, 5'b11111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
